// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Combinational full adder built from two half-add stages and an OR of the partial carries.
module fa_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   logic h1_s, h1_c, h2_c;

   assign h1_s = x ^ y;
   assign h1_c = x & y;
   assign s    = h1_s ^ ci;
   assign h2_c = h1_s & ci;
   assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one full add per cycle, WIDTH+1 cycles from start to done.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [WIDTH-2:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             fa_s, fa_co;

   fa_cell u_fa (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   assign last    = (cnt == CNT_W'(WIDTH - 1));
   // New bit enters at the MSB; the partial result only reaches sum on the last edge
   assign acc_nxt = {fa_s, acc};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         SHIFT:   busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr  <= '0;
         b_sr  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               acc   <= acc_nxt[WIDTH-1:1];
               carry <= fa_co;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  sum  <= acc_nxt;
                  cout <= fa_co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): vector table plus multi-cycle corner sequences.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         cin;
   logic         busy, done;
   logic [W-1:0] sum;
   logic         cout;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         co;
      string        nm;
   } vec_t;

   vec_t vecs[8];

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Caller is at a negedge with rst_n=1; returns at the negedge of the following IDLE cycle.
   task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W-1:0] es, input logic eco, input string nm);
      int k, bc;
      start = 1'b1; a = va; b = vb; cin = vc;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
      k = 1; bc = 0;
      while (k <= 40 && !done) begin
         if (busy) bc++;
         @(negedge clk);
         k++;
      end
      check({nm, " latency"}, k, W + 1);
      check({nm, " busy cycles"}, bc, W);
      check({nm, " busy at done"}, busy, 0);
      check({nm, " sum"}, sum, es);
      check({nm, " cout"}, cout, eco);
      @(negedge clk);
      check({nm, " done one cycle"}, done, 0);
   endtask

   initial begin
      int k, nd, t1, t2;

      vecs[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "v3c_42"};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "vff_01"};
      vecs[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, "v5a_a5_c"};
      vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "vzero"};
      vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, "v80_80_c"};
      vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, "v7f_00_c"};
      vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "vff_ff_c"};
      vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "v12_34"};

      rst_n = 1'b0; start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
      repeat (3) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset sum", sum, 0);
      check("reset cout", cout, 0);

      // first edge with rst_n=1 accepts the start (do_op drives it at this negedge)
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].nm);

      // sum holds in IDLE and through a new op until its final edge
      start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("hold sum during shift", sum, 8'h46);
      repeat (2) @(negedge clk);
      // ignored start mid-SHIFT with different operands
      start = 1'b1; a = 8'h11; b = 8'h11;
      @(negedge clk);
      start = 1'b0;
      k = 4; nd = 0;
      while (k <= 40 && !done) begin
         @(negedge clk);
         k++;
      end
      check("midstart latency", k, W + 1);
      check("midstart sum", sum, 8'h02);
      check("midstart cout", cout, 0);
      repeat (15) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("midstart no second done", nd, 0);
      check("midstart sum held", sum, 8'h02);

      // reset during the 4th SHIFT cycle aborts without a done pulse
      start = 1'b1; a = 8'h3C; b = 8'h42; cin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort busy before reset", busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort busy", busy, 0);
      check("abort done", done, 0);
      check("abort sum", sum, 0);
      check("abort cout", cout, 0);
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("abort no done", nd, 0);
      do_op(8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, "after_abort");

      // start held high: second op accepted right after DONE
      start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
      @(posedge clk);
      k = 0; nd = 0; t1 = 0; t2 = 0;
      while (k < 40 && nd < 2) begin
         @(negedge clk);
         k++;
         if (done) begin
            nd++;
            if (nd == 1) begin
               t1 = k;
               check("b2b first sum", sum, 8'h03);
               a = 8'h10; b = 8'h20;
            end else begin
               t2 = k;
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      check("b2b done count", nd, 2);
      check("b2b first latency", t1, W + 1);
      check("b2b spacing", t2 - t1, W + 2);
      check("b2b second sum", sum, 8'h30);
      repeat (2) @(negedge clk);
      check("b2b idle after", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 cin  input  1  carry-in; captured on the accepted start edge.
REQ-008 busy  output  1  high while bits are being processed (SHIFT state).
REQ-009 done  output  1  one-cycle pulse; sum/cout valid from this cycle on.
REQ-010 sum  output  WIDTH  result bits; registered.
REQ-011 cout  output  1  final carry-out; registered.

Function
REQ-012 The FSM SHALL have three states, IDLE, SHIFT and DONE, encoded as 2 bits.
REQ-013 In IDLE with start=1 at an edge: a, b and cin are loaded into the A shift register, B shift register and carry flop, the bit counter is cleared to 0, and the state goes to SHIFT.
REQ-014 Each SHIFT edge: a full add of A_sr[0], B_sr[0] and carry is performed; the sum bit enters the MSB of the sum shift register; A_sr and B_sr shift right; the carry flop takes the carry-out; the counter increments.
REQ-015 The full add SHALL be two half-add stages plus an OR of the two partial carries.
REQ-016 Processing is LSB first; after exactly WIDTH SHIFT edges, bit i of the result is in sum[i].
REQ-017 When the counter reaches WIDTH-1 at a SHIFT edge, the state goes to DONE; at that edge sum and cout take their final values.
REQ-018 done=1 in DONE only (one cycle); the next edge goes to IDLE regardless of start.
REQ-019 Latency: start accepted at edge E0; done is high in the cycle after edge E0+WIDTH; the total is WIDTH+1 cycles start-to-done.
REQ-020 busy=1 exactly in SHIFT (WIDTH cycles); busy=0 in IDLE and DONE.
REQ-021 start while in SHIFT or DONE is ignored; there is no queuing and operands are not re-sampled.
REQ-022 sum and cout hold their last result in IDLE until the next operation's DONE edge; they are not cleared by a new start.
REQ-023 a, b and cin are don't-care except on the accepted start edge.
REQ-024 Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); there is no overflow flag beyond cout.
REQ-025 A back-to-back start, asserted in the IDLE cycle immediately after DONE, is accepted; the sustained throughput is one result per WIDTH+2 cycles.

Reset
REQ-026 rst_n=0 at an edge forces state IDLE and sets counter, shift registers, carry, sum, cout, busy and done to 0.
REQ-027 Reset SHALL abort an in-progress operation with no done pulse; reset has priority over start.
REQ-028 The first start can be accepted at the first edge with rst_n=1.

Structure
REQ-029 A shared package/header serial_adder_pkg SHALL hold the state encodings (IDLE=0, SHIFT=1, DONE=2) and the default WIDTH.
REQ-030 One sub-module, fa_cell, SHALL be combinational: inputs x, y, ci; outputs s, co; two half-add stages plus OR; instantiated once.
REQ-031 The counter width SHALL be clog2(WIDTH)+1 bits.

Verification (WIDTH=8)
REQ-032 a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0; done exactly 9 cycles after the start edge; busy high 8 cycles.
REQ-033 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
REQ-034 a=0x5A, b=0xA5, cin=1 -> sum=0x00, cout=1; a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
REQ-035 start pulsed with a=0x11 mid-SHIFT of an op on 0x01+0x01 -> result 0x02 unaffected; no second done.
REQ-036 rst_n=0 for one edge at the 4th SHIFT cycle -> busy=0, done never pulses, sum=0, cout=0; a new start then completes correctly.
REQ-037 start held high continuously over two operations -> the second op is accepted in the IDLE cycle after DONE; done pulses 10 cycles apart.
